// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS-subset instruction decoder feeding a DEPTH-entry output queue
// Decode is purely combinational from in_inst; the decoded record is queued with its PC.
module decode_stage #(
  parameter int DEPTH   = 4,
  parameter int EXT_OPS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [31:0]             in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_pc,
  output logic [2:0]              out_alu_sel,
  output logic [7:0]              out_alu_op,
  output logic [4:0]              out_rs,
  output logic [4:0]              out_rt,
  output logic [4:0]              out_wdest,
  output logic [4:0]              out_shamt,
  output logic [31:0]             out_imm,
  output logic                    out_reg_write,
  output logic                    out_is_branch,
  output logic                    out_is_load,
  output logic                    out_is_store,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] SEL_LOGIC = 3'd0;
  localparam logic [2:0] SEL_SHIFT = 3'd1;
  localparam logic [2:0] SEL_ARITH = 3'd2;
  localparam logic [2:0] SEL_NOP   = 3'd3;
  localparam logic [2:0] SEL_MOVE  = 3'd4;
  localparam logic [2:0] SEL_JUMP  = 3'd5;
  localparam logic [2:0] SEL_LDST  = 3'd6;

  localparam logic [7:0] OP_OR   = 8'd0;
  localparam logic [7:0] OP_AND  = 8'd1;
  localparam logic [7:0] OP_XOR  = 8'd2;
  localparam logic [7:0] OP_LUI  = 8'd4;
  localparam logic [7:0] OP_SLL  = 8'd5;
  localparam logic [7:0] OP_SRL  = 8'd6;
  localparam logic [7:0] OP_ADD  = 8'd7;
  localparam logic [7:0] OP_JAL  = 8'd8;
  localparam logic [7:0] OP_BEQ  = 8'd9;
  localparam logic [7:0] OP_LW   = 8'd10;
  localparam logic [7:0] OP_LB   = 8'd11;
  localparam logic [7:0] OP_SB   = 8'd12;
  localparam logic [7:0] OP_SW   = 8'd13;
  localparam logic [7:0] OP_SUB  = 8'd14;
  localparam logic [7:0] OP_SLT  = 8'd15;
  localparam logic [7:0] OP_BNE  = 8'd16;
  localparam logic [7:0] OP_BGTZ = 8'd17;
  localparam logic [7:0] OP_BLEZ = 8'd18;
  localparam logic [7:0] OP_J    = 8'd19;
  localparam logic [7:0] OP_JR   = 8'd20;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_BNE     = 6'b000101;
  localparam logic [5:0] OPC_BLEZ    = 6'b000110;
  localparam logic [5:0] OPC_BGTZ    = 6'b000111;
  localparam logic [5:0] OPC_ADDIU   = 6'b001001;
  localparam logic [5:0] OPC_ANDI    = 6'b001100;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_XORI    = 6'b001110;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_LB      = 6'b100000;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SB      = 6'b101000;
  localparam logic [5:0] OPC_SW      = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wdest;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        reg_write;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } entry_t;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rd;
  logic       ext_en;
  logic       writes;
  entry_t     dec;

  assign opcode = in_inst[31:26];
  assign funct  = in_inst[5:0];
  assign rd     = in_inst[15:11];
  assign ext_en = (EXT_OPS != 0);

  always_comb begin
    dec           = '0;
    writes        = 1'b0;
    dec.pc        = in_pc;
    dec.rs        = in_inst[25:21];
    dec.rt        = in_inst[20:16];
    dec.shamt     = in_inst[10:6];
    dec.imm       = {{16{in_inst[15]}}, in_inst[15:0]};
    dec.alu_sel   = SEL_NOP;
    dec.alu_op    = OP_OR;
    case (opcode)
      OPC_SPECIAL: begin
        dec.wdest = rd;
        case (funct)
          FN_SLL: begin
            dec.alu_op = OP_SLL;
            // The all-zero word is the canonical NOP, not a real shift.
            if (in_inst != 32'd0) begin
              dec.alu_sel = SEL_SHIFT;
              writes      = 1'b1;
            end
          end
          FN_SRL:  begin dec.alu_sel = SEL_SHIFT; dec.alu_op = OP_SRL; writes = 1'b1; end
          FN_JR:   begin dec.alu_sel = SEL_JUMP;  dec.alu_op = OP_JR; end
          FN_ADDU: begin dec.alu_sel = SEL_ARITH; dec.alu_op = OP_ADD; writes = 1'b1; end
          FN_AND:  begin dec.alu_sel = SEL_LOGIC; dec.alu_op = OP_AND; writes = 1'b1; end
          FN_OR:   begin dec.alu_sel = SEL_LOGIC; dec.alu_op = OP_OR;  writes = 1'b1; end
          FN_XOR:  begin dec.alu_sel = SEL_LOGIC; dec.alu_op = OP_XOR; writes = 1'b1; end
          FN_SUBU: begin
            if (ext_en) begin dec.alu_sel = SEL_ARITH; dec.alu_op = OP_SUB; writes = 1'b1; end
            else dec.illegal = 1'b1;
          end
          FN_SLT: begin
            if (ext_en) begin dec.alu_sel = SEL_ARITH; dec.alu_op = OP_SLT; writes = 1'b1; end
            else dec.illegal = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_J:    begin dec.alu_sel = SEL_JUMP; dec.alu_op = OP_J; end
      OPC_JAL:  begin dec.alu_sel = SEL_JUMP; dec.alu_op = OP_JAL; dec.wdest = 5'd31; writes = 1'b1; end
      OPC_BEQ:  begin dec.alu_sel = SEL_JUMP; dec.alu_op = OP_BEQ;  dec.is_branch = 1'b1; end
      OPC_BNE:  begin dec.alu_sel = SEL_JUMP; dec.alu_op = OP_BNE;  dec.is_branch = 1'b1; end
      OPC_BGTZ: begin dec.alu_sel = SEL_JUMP; dec.alu_op = OP_BGTZ; dec.is_branch = 1'b1; end
      OPC_BLEZ: begin
        if (ext_en) begin dec.alu_sel = SEL_JUMP; dec.alu_op = OP_BLEZ; dec.is_branch = 1'b1; end
        else dec.illegal = 1'b1;
      end
      OPC_ADDIU: begin dec.alu_sel = SEL_ARITH; dec.alu_op = OP_ADD; dec.wdest = dec.rt; writes = 1'b1; end
      OPC_ANDI: begin
        dec.alu_sel = SEL_LOGIC; dec.alu_op = OP_AND; dec.wdest = dec.rt; writes = 1'b1;
        dec.imm = {16'h0000, in_inst[15:0]};
      end
      OPC_ORI: begin
        dec.alu_sel = SEL_LOGIC; dec.alu_op = OP_OR; dec.wdest = dec.rt; writes = 1'b1;
        dec.imm = {16'h0000, in_inst[15:0]};
      end
      OPC_XORI: begin
        dec.alu_sel = SEL_LOGIC; dec.alu_op = OP_XOR; dec.wdest = dec.rt; writes = 1'b1;
        dec.imm = {16'h0000, in_inst[15:0]};
      end
      OPC_LUI: begin
        dec.alu_sel = SEL_MOVE; dec.alu_op = OP_LUI; dec.wdest = dec.rt; writes = 1'b1;
        dec.imm = {in_inst[15:0], 16'h0000};
      end
      OPC_LB: begin dec.alu_sel = SEL_LDST; dec.alu_op = OP_LB; dec.wdest = dec.rt; writes = 1'b1; dec.is_load = 1'b1; end
      OPC_LW: begin dec.alu_sel = SEL_LDST; dec.alu_op = OP_LW; dec.wdest = dec.rt; writes = 1'b1; dec.is_load = 1'b1; end
      OPC_SB: begin dec.alu_sel = SEL_LDST; dec.alu_op = OP_SB; dec.is_store = 1'b1; end
      OPC_SW: begin dec.alu_sel = SEL_LDST; dec.alu_op = OP_SW; dec.is_store = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
    dec.reg_write = writes && (dec.wdest != 5'd0);
  end

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // in_ready looks only at occupancy, so a full queue never accepts even on a popping edge.
  assign in_ready  = !rst && (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign out_pc        = head.pc;
  assign out_alu_sel   = head.alu_sel;
  assign out_alu_op    = head.alu_op;
  assign out_rs        = head.rs;
  assign out_rt        = head.rt;
  assign out_wdest     = head.wdest;
  assign out_shamt     = head.shamt;
  assign out_imm       = head.imm;
  assign out_reg_write = head.reg_write;
  assign out_is_branch = head.is_branch;
  assign out_is_load   = head.is_load;
  assign out_is_store  = head.is_store;
  assign out_illegal   = out_valid && head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and random checks of decode_stage against a table-driven model
module tb_decode_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid, out_reg_write, out_is_branch, out_is_load, out_is_store, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [2:0]  out_alu_sel, count;
  logic [7:0]  out_alu_op;
  logic [4:0]  out_rs, out_rt, out_wdest, out_shamt;

  logic        b_in_ready, b_out_valid, b_reg_write, b_is_branch, b_is_load, b_is_store, b_illegal;
  logic [31:0] b_pc, b_imm;
  logic [2:0]  b_alu_sel, b_count;
  logic [7:0]  b_alu_op;
  logic [4:0]  b_rs, b_rt, b_wdest, b_shamt;

  always #5 clk = ~clk;

  decode_stage #(.DEPTH(DEPTH), .EXT_OPS(1)) u_main (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu_sel(out_alu_sel), .out_alu_op(out_alu_op), .out_rs(out_rs),
    .out_rt(out_rt), .out_wdest(out_wdest), .out_shamt(out_shamt), .out_imm(out_imm),
    .out_reg_write(out_reg_write), .out_is_branch(out_is_branch), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .out_illegal(out_illegal), .count(count));

  decode_stage #(.DEPTH(DEPTH), .EXT_OPS(0)) u_base (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_alu_sel(b_alu_sel), .out_alu_op(b_alu_op), .out_rs(b_rs),
    .out_rt(b_rt), .out_wdest(b_wdest), .out_shamt(b_shamt), .out_imm(b_imm),
    .out_reg_write(b_reg_write), .out_is_branch(b_is_branch), .out_is_load(b_is_load),
    .out_is_store(b_is_store), .out_illegal(b_illegal), .count(b_count));

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [4:0]  rs, rt, wdest, shamt;
    logic [31:0] imm;
    logic        rw, br, ld, st, ill;
  } rec_t;

  // immk: 0 sign-extend, 1 zero-extend, 2 upper half. dk: 0 none, 1 rd, 2 rt, 3 link register.
  typedef struct {
    logic [5:0] opc;
    int         funct;
    int         sel, op, immk, dk;
    bit         wr, br, ld, st, ext;
  } row_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  row_t tbl[$];
  ent_t q[$];
  int   errors = 0;
  int   checks = 0;
  rec_t o_main, o_base;

  assign o_main = {out_pc, out_alu_sel, out_alu_op, out_rs, out_rt, out_wdest, out_shamt, out_imm,
                   out_reg_write, out_is_branch, out_is_load, out_is_store, out_illegal};
  assign o_base = {b_pc, b_alu_sel, b_alu_op, b_rs, b_rt, b_wdest, b_shamt, b_imm,
                   b_reg_write, b_is_branch, b_is_load, b_is_store, b_illegal};

  task automatic add_row(input logic [5:0] opc, input int funct, input int sel, input int op,
                         input int immk, input int dk, input bit wr, input bit br, input bit ld,
                         input bit st, input bit ext);
    row_t r;
    r.opc = opc; r.funct = funct; r.sel = sel; r.op = op; r.immk = immk; r.dk = dk;
    r.wr = wr; r.br = br; r.ld = ld; r.st = st; r.ext = ext;
    tbl.push_back(r);
  endtask

  function automatic rec_t model(input logic [31:0] inst, input logic [31:0] pc, input bit ext);
    rec_t e;
    int   hit;
    e = '0;
    hit = -1;
    e.pc = pc; e.rs = inst[25:21]; e.rt = inst[20:16]; e.shamt = inst[10:6];
    e.sel = 3'd3; e.op = 8'd0;
    if (inst == 32'd0) begin
      e.op = 8'd5;
      return e;
    end
    foreach (tbl[i])
      if (hit < 0 && tbl[i].opc == inst[31:26] && (tbl[i].funct < 0 || tbl[i].funct == int'(inst[5:0]))
          && (ext || !tbl[i].ext))
        hit = i;
    if (hit < 0) begin
      e.ill = 1'b1;
      return e;
    end
    e.sel = 3'(tbl[hit].sel);
    e.op  = 8'(tbl[hit].op);
    if (tbl[hit].immk == 1)      e.imm = 32'(inst[15:0]);
    else if (tbl[hit].immk == 2) e.imm = 32'(inst[15:0]) * 32'd65536;
    else                         e.imm = 32'($signed(inst[15:0]));
    if (tbl[hit].dk == 1)      e.wdest = inst[15:11];
    else if (tbl[hit].dk == 2) e.wdest = inst[20:16];
    else if (tbl[hit].dk == 3) e.wdest = 5'd31;
    e.rw = tbl[hit].wr && (e.wdest != 5'd0);
    e.br = tbl[hit].br; e.ld = tbl[hit].ld; e.st = tbl[hit].st;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string who, input rec_t o, input rec_t e);
    chk({who, ".pc"}, o.pc, e.pc);
    chk({who, ".alu_sel"}, 32'(o.sel), 32'(e.sel));
    chk({who, ".alu_op"}, 32'(o.op), 32'(e.op));
    chk({who, ".reg_write"}, 32'(o.rw), 32'(e.rw));
    chk({who, ".is_branch"}, 32'(o.br), 32'(e.br));
    chk({who, ".is_load"}, 32'(o.ld), 32'(e.ld));
    chk({who, ".is_store"}, 32'(o.st), 32'(e.st));
    chk({who, ".illegal"}, 32'(o.ill), 32'(e.ill));
    if (!e.ill) begin
      chk({who, ".rs"}, 32'(o.rs), 32'(e.rs));
      chk({who, ".rt"}, 32'(o.rt), 32'(e.rt));
      chk({who, ".wdest"}, 32'(o.wdest), 32'(e.wdest));
      chk({who, ".shamt"}, 32'(o.shamt), 32'(e.shamt));
      chk({who, ".imm"}, o.imm, e.imm);
    end
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("base.count", 32'(b_count), 32'(n));
    chk("base.in_ready", 32'(b_in_ready), 32'(n < DEPTH));
    chk("base.out_valid", 32'(b_out_valid), 32'(n != 0));
    if (n == 0) begin
      chk("idle_illegal", 32'(out_illegal), 32'd0);
      chk("base.idle_illegal", 32'(b_illegal), 32'd0);
    end else begin
      chk_rec("main", o_main, model(q[0].inst, q[0].pc, 1'b1));
      chk_rec("base", o_base, model(q[0].inst, q[0].pc, 1'b0));
    end
  endtask

  // Called just after a rising edge; checks at the falling edge, then advances one cycle.
  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input bit rdy, input bit fl);
    bit   do_push, do_pop;
    ent_t ne;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl;
    @(negedge clk);
    check_state();
    do_push = v && (q.size() < DEPTH) && !fl;
    do_pop  = (q.size() != 0) && rdy && !fl;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (do_pop) q.delete(0);
      if (do_push) begin
        ne.inst = inst; ne.pc = pc;
        q.push_back(ne);
      end
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int          k, r;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 6) begin
      r = $urandom_range(0, tbl.size() - 1);
      w[31:26] = tbl[r].opc;
      if (tbl[r].funct >= 0) w[5:0] = 6'(tbl[r].funct);
    end else if (k == 6) begin
      w = 32'd0;
    end
    return w;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;

    add_row(6'h00, 'h24, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    add_row(6'h00, 'h25, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add_row(6'h00, 'h26, 0, 2, 0, 1, 1, 0, 0, 0, 0);
    add_row(6'h00, 'h00, 1, 5, 0, 1, 1, 0, 0, 0, 0);
    add_row(6'h00, 'h02, 1, 6, 0, 1, 1, 0, 0, 0, 0);
    add_row(6'h00, 'h08, 5, 20, 0, 1, 0, 0, 0, 0, 0);
    add_row(6'h00, 'h21, 2, 7, 0, 1, 1, 0, 0, 0, 0);
    add_row(6'h00, 'h23, 2, 14, 0, 1, 1, 0, 0, 0, 1);
    add_row(6'h00, 'h2a, 2, 15, 0, 1, 1, 0, 0, 0, 1);
    add_row(6'h02, -1, 5, 19, 0, 0, 0, 0, 0, 0, 0);
    add_row(6'h03, -1, 5, 8, 0, 3, 1, 0, 0, 0, 0);
    add_row(6'h04, -1, 5, 9, 0, 0, 0, 1, 0, 0, 0);
    add_row(6'h05, -1, 5, 16, 0, 0, 0, 1, 0, 0, 0);
    add_row(6'h06, -1, 5, 18, 0, 0, 0, 1, 0, 0, 1);
    add_row(6'h07, -1, 5, 17, 0, 0, 0, 1, 0, 0, 0);
    add_row(6'h09, -1, 2, 7, 0, 2, 1, 0, 0, 0, 0);
    add_row(6'h0c, -1, 0, 1, 1, 2, 1, 0, 0, 0, 0);
    add_row(6'h0d, -1, 0, 0, 1, 2, 1, 0, 0, 0, 0);
    add_row(6'h0e, -1, 0, 2, 1, 2, 1, 0, 0, 0, 0);
    add_row(6'h0f, -1, 4, 4, 2, 2, 1, 0, 0, 0, 0);
    add_row(6'h20, -1, 6, 11, 0, 2, 1, 0, 1, 0, 0);
    add_row(6'h23, -1, 6, 10, 0, 2, 1, 0, 1, 0, 0);
    add_row(6'h28, -1, 6, 12, 0, 0, 0, 0, 0, 1, 0);
    add_row(6'h2b, -1, 6, 13, 0, 0, 0, 0, 0, 1, 0);

    @(posedge clk);
    #1;
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_illegal", 32'(out_illegal), 32'd0);
    #6;
    rst = 1'b0;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    step(1'b1, 32'h34011234, 32'h0000_1000, 1'b1, 1'b0);
    chk("ori.out_valid", 32'(out_valid), 32'd1);
    chk("ori.sel", 32'(out_alu_sel), 32'd0);
    chk("ori.op", 32'(out_alu_op), 32'd0);
    chk("ori.wdest", 32'(out_wdest), 32'd1);
    chk("ori.imm", out_imm, 32'h0000_1234);
    chk("ori.reg_write", 32'(out_reg_write), 32'd1);

    step(1'b1, 32'h2422FFFF, 32'h0000_1004, 1'b1, 1'b0);
    chk("addiu.count", 32'(count), 32'd1);
    chk("addiu.sel", 32'(out_alu_sel), 32'd2);
    chk("addiu.op", 32'(out_alu_op), 32'd7);
    chk("addiu.rs", 32'(out_rs), 32'd1);
    chk("addiu.wdest", 32'(out_wdest), 32'd2);
    chk("addiu.imm", out_imm, 32'hFFFF_FFFF);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) step(1'b1, rand_inst(), 32'h2000 + 32'(4 * i), 1'b0, 1'b0);
    chk("full.count", 32'(count), 32'd4);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("full.pop_pc", out_pc, 32'h2000 + 32'(4 * i));
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    chk("drained.out_valid", 32'(out_valid), 32'd0);

    step(1'b1, 32'h00221823, 32'h0000_3000, 1'b0, 1'b0);
    chk("subu.sel", 32'(out_alu_sel), 32'd2);
    chk("subu.op", 32'(out_alu_op), 32'd14);
    chk("subu.wdest", 32'(out_wdest), 32'd3);
    chk("subu_base.illegal", 32'(b_illegal), 32'd1);
    chk("subu_base.reg_write", 32'(b_reg_write), 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    step(1'b1, 32'd0, 32'h0000_4000, 1'b0, 1'b0);
    chk("nop.sel", 32'(out_alu_sel), 32'd3);
    chk("nop.op", 32'(out_alu_op), 32'd5);
    chk("nop.reg_write", 32'(out_reg_write), 32'd0);
    chk("nop.illegal", 32'(out_illegal), 32'd0);
    step(1'b1, 32'hFC00_0000, 32'h0000_4004, 1'b1, 1'b0);
    chk("bad.sel", 32'(out_alu_sel), 32'd3);
    chk("bad.op", 32'(out_alu_op), 32'd0);
    chk("bad.illegal", 32'(out_illegal), 32'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) step(1'b1, rand_inst(), 32'h5000 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 32'h34011234, 32'hDEAD_0000, 1'b0, 1'b1);
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    step(1'b1, rand_inst(), 32'h6000, 1'b0, 1'b0);
    step(1'b1, rand_inst(), 32'h6004, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.in_ready", 32'(in_ready), 32'd0);
    chk("async_rst.out_illegal", 32'(out_illegal), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);
    chk("post_rst.count", 32'(count), 32'd0);

    repeat (3000)
      step($urandom_range(0, 9) < 7, rand_inst(), $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 31) == 0);
    repeat (DEPTH + 1) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output queue entries (power of two, 2..16).
REQ-002 SHALL have parameter EXT_OPS, default 1, which enables the extended opcode set when 1 and keeps the base set only when 0.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 flush  input  1  synchronous queue clear (branch redirect).
REQ-006 in_valid / in_ready  input / output  1 / 1  fetch-side handshake.
REQ-007 in_inst / in_pc  input  32 / 32  instruction word and its PC.
REQ-008 out_valid / out_ready  output / input  1 / 1  execute-side handshake.
REQ-009 out_pc  output  32  PC of the head entry.
REQ-010 out_alu_sel / out_alu_op  output  3 / 8  ALU class and operation codes.
REQ-011 out_rs, out_rt, out_wdest, out_shamt  output  5 each  source registers, destination register, shift amount.
REQ-012 out_imm  output  32  extended immediate.
REQ-013 out_reg_write, out_is_branch, out_is_load, out_is_store, out_illegal  output  1 each  control flags.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 alu_sel codes SHALL be: LOGIC=0, SHIFT=1, ARITH=2, NOP=3, MOVE=4, JUMP=5, LOAD_STORE=6.
REQ-016 alu_op codes SHALL be: OR=0, AND=1, XOR=2, NOR=3, LUI=4, SLL=5, SRL=6, ADD=7, JAL=8, BEQ=9, LW=10, LB=11, SB=12, SW=13, SUB=14, SLT=15, BNE=16, BGTZ=17, BLEZ=18, J=19, JR=20.
REQ-017 Base set SHALL be: ANDI, ORI, XORI, LUI, ADDIU, BEQ, BNE, BGTZ, J, JAL, JR, LB, LW, SB, SW, plus R-type AND, OR, XOR, SLL, SRL, JR, ADDU.
REQ-018 With EXT_OPS=1 the block SHALL also decode R-type SUBU (funct 100011), R-type SLT (funct 101010) and BLEZ (opcode 000110).
REQ-019 Immediate SHALL be zero-extended for ANDI/ORI/XORI, equal to imm<<16 for LUI, and sign-extended otherwise; branch offsets SHALL be passed unshifted.
REQ-020 wdest SHALL be rd for R-type, rt for I-type ALU ops and loads, and 31 for JAL.
REQ-021 reg_write SHALL be 0 for branches, stores, J, JR and any wdest of 0.
REQ-022 The all-zero word SHALL decode as sel NOP, op SLL, reg_write 0, illegal 0.
REQ-023 An unsupported opcode/funct (including extended ops when EXT_OPS=0) SHALL decode as sel NOP, op OR, reg_write 0, all is_* flags 0, illegal 1.
REQ-024 Decode SHALL be combinational from in_inst; the decoded record plus in_pc SHALL be written into a circular queue of DEPTH entries on clk when in_valid&&in_ready.
REQ-025 in_ready SHALL be !full, with no same-cycle bypass when full even if a pop occurs.
REQ-026 out_valid SHALL be !empty, and the out_* fields SHALL show the head entry.
REQ-027 An entry SHALL be popped on the edge where out_valid&&out_ready.
REQ-028 Latency SHALL be 1 cycle: an instruction accepted at edge N appears at the output after edge N if the queue was empty.
REQ-029 Simultaneous push and pop when not full and not empty SHALL leave count unchanged and advance both pointers.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 Output fields while out_valid=0 SHALL be don't-care, except out_illegal, which SHALL be 0.
REQ-032 flush=1 SHALL set count, read pointer and write pointer to 0 at the next edge; a push in the same cycle SHALL be discarded, and flush SHALL take priority over push and pop.
REQ-033 out_valid/out_ready SHALL follow AXI-style rules: once out_valid=1 the head entry SHALL stay stable until popped or flushed.

Reset
REQ-034 While rst=1, count=0, pointers=0, out_valid=0, in_ready=0, out_illegal=0.
REQ-035 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-036 Reset asserted mid-transfer SHALL discard all queued entries immediately (asynchronously).
REQ-037 Queue storage SHALL need no reset.

Verification
REQ-038 Push 0x34011234 (ori $1,$0,0x1234), out_ready=1 -> next cycle out_valid=1, sel=0, op=0, wdest=1, imm=0x00001234, reg_write=1.
REQ-039 Push 0x2422FFFF (addiu $2,$1,-1) -> sel=2, op=7, rs=1, wdest=2, imm=0xFFFFFFFF.
REQ-040 DEPTH=4, out_ready=0, 5 pushes offered -> count=4, in_ready=0, fifth word not accepted; 4 pops return PCs in order.
REQ-041 EXT_OPS=0, push 0x00221823 (subu) -> illegal=1, reg_write=0; with EXT_OPS=1 the same word -> sel=2, op=14, wdest=3.
REQ-042 3 entries queued, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, pushed word absent.
REQ-043 rst pulsed between edges with 2 entries queued -> out_valid=0 immediately, count=0, in_ready=1 one cycle after release.
